// File: rtl/apb4_completer_regfile_if.sv
// APB4 bus bundle between a requester and the register-file completer.
interface apb4_completer_regfile_if #(
  parameter int unsigned PADDR_SIZE = 8,
  parameter int unsigned PDATA_SIZE = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [PADDR_SIZE-1:0]   paddr;
  logic [PDATA_SIZE/8-1:0] pstrb;
  logic [PDATA_SIZE-1:0]   pwdata;
  logic [PDATA_SIZE-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pstrb, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pstrb, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_completer_regfile.sv
// APB4 completer exposing NUM_REGS data-width registers with a fixed number of wait states.
module apb4_completer_regfile #(
  parameter int unsigned PADDR_SIZE  = 8,
  parameter int unsigned PDATA_SIZE  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic                     pclk,
  input logic                     preset,
  apb4_completer_regfile_if.slave apb
);

  localparam int unsigned StrbW     = PDATA_SIZE / 8;
  localparam int unsigned AlignBits = (StrbW > 1) ? $clog2(StrbW) : 0;
  localparam int unsigned RegIdxW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [PADDR_SIZE-1:0] AlignMask = PADDR_SIZE'((1 << AlignBits) - 1);
  localparam logic [3:0] WaitCnt = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [PADDR_SIZE-1:0]   addr_q;
  logic [RegIdxW-1:0]      reg_idx_q;
  logic                    write_q;
  logic [StrbW-1:0]        strb_q;
  logic [PDATA_SIZE-1:0]   wdata_q;
  logic [PDATA_SIZE-1:0]   regs_q [NUM_REGS];

  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [PDATA_SIZE-1:0]   prdata_q, prdata_d;

  logic                    setup;
  logic                    commit;
  logic [PADDR_SIZE-1:0]   sel_addr;
  logic                    sel_write;
  logic [PADDR_SIZE-1:0]   sel_idx;
  logic [RegIdxW-1:0]      sel_reg_idx;
  logic                    sel_err;

  assign setup = apb.psel && !apb.penable;

  // In IDLE the transfer is being captured this very edge, so decode the live bus;
  // afterwards only the captured copy counts.
  assign sel_addr    = (state_q == StIdle) ? apb.paddr : addr_q;
  assign sel_write   = (state_q == StIdle) ? apb.pwrite : write_q;
  assign sel_idx     = sel_addr >> AlignBits;
  assign sel_reg_idx = sel_idx[RegIdxW-1:0];
  assign sel_err     = ((sel_addr & AlignMask) != '0) || (32'(sel_idx) >= NUM_REGS);

  // State and wait counter register
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: setup -> wait states -> single DONE cycle, abort on dropped psel/penable
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (setup) begin
          cnt_d   = WaitCnt;
          state_d = (WAIT_CYCLES == 0) ? StDone : StWait;
        end
      end
      StWait: begin
        if (!(apb.psel && apb.penable)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: response registers are loaded on the edge entering DONE, zero elsewhere
  always_comb begin
    pready_d  = (state_d == StDone);
    pslverr_d = 1'b0;
    prdata_d  = '0;
    if (state_d == StDone) begin
      pslverr_d = sel_err;
      if (!sel_err && !sel_write) prdata_d = regs_q[sel_reg_idx];
    end
    commit = (state_q == StDone) && apb.psel && apb.penable && write_q && !pslverr_q;
  end

  // Response registers
  always_ff @(posedge pclk) begin
    if (preset) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Capture the transfer attributes at the setup edge; later bus changes are ignored
  always_ff @(posedge pclk) begin
    if (preset) begin
      addr_q    <= '0;
      reg_idx_q <= '0;
      write_q   <= 1'b0;
      strb_q    <= '0;
      wdata_q   <= '0;
    end else if (state_q == StIdle && setup) begin
      addr_q    <= apb.paddr;
      reg_idx_q <= sel_reg_idx;
      write_q   <= apb.pwrite;
      strb_q    <= apb.pstrb;
      wdata_q   <= apb.pwdata;
    end
  end

  // Register file: byte-lane write commit at the end of the DONE cycle
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else if (commit) begin
      for (int b = 0; b < StrbW; b++) begin
        if (strb_q[b]) regs_q[reg_idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
      end
    end
  end

  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata  = prdata_q;

endmodule

// File: tb/tb_apb4_completer_regfile.sv
// Scoreboard bench for the APB4 register-file completer: the driver queues expected
// responses, the monitor checks them whenever pready rises.
module tb_apb4_completer_regfile;

  localparam int unsigned WAIT = 1;

  typedef struct {
    logic [31:0] data;
    bit          err;
    bit          chk_data;
    int          cyc;
    string       name;
  } exp_t;

  logic pclk;
  logic preset;
  int   cyc;
  int   checks;
  int   errors;
  int   pulses;
  bit   mon_en;
  bit   prev_pready;
  exp_t q[$];

  apb4_completer_regfile_if #(.PADDR_SIZE(8), .PDATA_SIZE(32)) apb ();

  apb4_completer_regfile #(
    .PADDR_SIZE (8),
    .PDATA_SIZE (32),
    .NUM_REGS   (16),
    .WAIT_CYCLES(WAIT)
  ) dut (
    .pclk  (pclk),
    .preset(preset),
    .apb   (apb)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Monitor: pop and compare on every pready, police idle outputs and pulse width
  always @(negedge pclk) begin
    exp_t e;
    if (mon_en) begin
      if (apb.pready) begin
        pulses++;
        checks++;
        if (prev_pready) begin
          errors++;
          $display("FAIL pready_width: high for consecutive cycles at cycle %0d", cyc);
        end
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pready: got pready=1 at cycle %0d, want no response", cyc);
        end else begin
          e = q.pop_front();
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL %s timing: pready at cycle %0d, want %0d", e.name, cyc, e.cyc);
          end
          checks++;
          if (apb.pslverr != e.err) begin
            errors++;
            $display("FAIL %s pslverr: got %0b, want %0b", e.name, apb.pslverr, e.err);
          end
          if (e.chk_data) begin
            checks++;
            if (apb.prdata !== e.data) begin
              errors++;
              $display("FAIL %s prdata: got %08h, want %08h", e.name, apb.prdata, e.data);
            end
          end
        end
      end else begin
        checks++;
        if (apb.prdata !== 32'h0 || apb.pslverr !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs: prdata=%08h pslverr=%0b at cycle %0d, want 0/0",
                   apb.prdata, apb.pslverr, cyc);
        end
      end
      prev_pready = apb.pready;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk); #1;
      apb.psel    = 1'b0;
      apb.penable = 1'b0;
    end
  endtask

  // One complete transfer; returns in the DONE cycle so a following call is back-to-back.
  // late=1 disturbs paddr/pwdata after setup to prove they were captured.
  task automatic xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [31:0] exp_data, input bit exp_err,
                      input bit late, input string name);
    exp_t e;
    int   n;
    @(posedge pclk); #1;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = wr;
    apb.paddr   = addr;
    apb.pwdata  = wdata;
    apb.pstrb   = strb;
    e.data      = exp_data;
    e.err       = exp_err;
    e.chk_data  = !wr;
    e.cyc       = cyc + 1 + WAIT;
    e.name      = name;
    q.push_back(e);
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    if (late) begin
      apb.paddr  = addr ^ 8'h04;
      apb.pwdata = ~wdata;
    end
    n = 0;
    while (!apb.pready && n < 20) begin
      @(posedge pclk); #1;
      n++;
    end
    checks++;
    if (!apb.pready) begin
      errors++;
      $display("FAIL %s timeout: no pready after %0d cycles, want completion", name, n);
    end
  endtask

  task automatic expect_no_pulse(input int p0, input string name);
    checks++;
    if (pulses != p0) begin
      errors++;
      $display("FAIL %s: saw %0d pready pulses, want 0", name, pulses - p0);
    end
  endtask

  initial begin
    int p0;
    checks      = 0;
    errors      = 0;
    pulses      = 0;
    mon_en      = 1'b0;
    prev_pready = 1'b0;
    preset      = 1'b1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
    apb.paddr   = '0;
    apb.pwdata  = '0;
    apb.pstrb   = '0;

    repeat (2) @(posedge pclk);
    #1;
    checks++;
    if (apb.pready !== 1'b0) begin
      errors++;
      $display("FAIL reset_pready: got %0b, want 0", apb.pready);
    end
    checks++;
    if (apb.pslverr !== 1'b0) begin
      errors++;
      $display("FAIL reset_pslverr: got %0b, want 0", apb.pslverr);
    end
    checks++;
    if (apb.prdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_prdata: got %08h, want 00000000", apb.prdata);
    end
    preset = 1'b0;
    mon_en = 1'b1;

    xfer(1'b0, 8'h0C, 32'h0, 4'h0, 32'h0000_0000, 1'b0, 1'b0, "rd_0c_reset");
    xfer(1'b1, 8'h08, 32'hDEAD_BEEF, 4'b0101, 32'h0, 1'b0, 1'b0, "wr_08_lanes");
    xfer(1'b0, 8'h08, 32'h0, 4'h0, 32'h00AD_00EF, 1'b0, 1'b0, "rd_08_lanes");
    xfer(1'b0, 8'h40, 32'h0, 4'h0, 32'h0000_0000, 1'b1, 1'b0, "rd_40_oob");
    xfer(1'b1, 8'h41, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1'b0, "wr_41_oob");
    xfer(1'b0, 8'h09, 32'h0, 4'h0, 32'h0000_0000, 1'b1, 1'b0, "rd_09_unaligned");
    xfer(1'b1, 8'h08, 32'h1234_5678, 4'h0, 32'h0, 1'b0, 1'b0, "wr_08_nostrb");
    xfer(1'b0, 8'h08, 32'h0, 4'h0, 32'h00AD_00EF, 1'b0, 1'b0, "rd_08_after_err");
    xfer(1'b0, 8'h00, 32'h0, 4'h0, 32'h0000_0000, 1'b0, 1'b0, "rd_00_untouched");
    idle(1);

    xfer(1'b1, 8'h00, 32'h1111_1111, 4'hF, 32'h0, 1'b0, 1'b0, "b2b_wr_00");
    xfer(1'b1, 8'h04, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0, 1'b0, "b2b_wr_04");
    xfer(1'b0, 8'h00, 32'h0, 4'h0, 32'h1111_1111, 1'b0, 1'b0, "b2b_rd_00");
    xfer(1'b0, 8'h04, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0, 1'b0, "b2b_rd_04");
    idle(2);

    xfer(1'b1, 8'h10, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1'b0, "wr_10");
    idle(1);
    // Abort: psel dropped in the wait state
    p0 = pulses;
    @(posedge pclk); #1;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b1;
    apb.paddr   = 8'h10;
    apb.pwdata  = 32'h0BAD_BEEF;
    apb.pstrb   = 4'hF;
    @(posedge pclk); #1;
    apb.psel    = 1'b0;
    idle(3);
    expect_no_pulse(p0, "abort_pready");
    xfer(1'b0, 8'h10, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b0, "rd_10_after_abort");

    xfer(1'b1, 8'h18, 32'h600D_F00D, 4'hF, 32'h0, 1'b0, 1'b1, "wr_18_late_change");
    xfer(1'b0, 8'h18, 32'h0, 4'h0, 32'h600D_F00D, 1'b0, 1'b0, "rd_18_captured");
    xfer(1'b0, 8'h1C, 32'h0, 4'h0, 32'h0000_0000, 1'b0, 1'b0, "rd_1c_untouched");
    idle(1);

    // penable without a preceding setup cycle must start nothing
    p0 = pulses;
    @(posedge pclk); #1;
    apb.psel    = 1'b1;
    apb.penable = 1'b1;
    apb.pwrite  = 1'b1;
    apb.paddr   = 8'h00;
    apb.pwdata  = 32'hFFFF_FFFF;
    apb.pstrb   = 4'hF;
    repeat (3) @(posedge pclk);
    idle(3);
    expect_no_pulse(p0, "penable_only");
    xfer(1'b0, 8'h00, 32'h0, 4'h0, 32'h1111_1111, 1'b0, 1'b0, "rd_00_after_penable");
    idle(1);

    // Reset during the wait state of a write
    p0 = pulses;
    @(posedge pclk); #1;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b1;
    apb.paddr   = 8'h14;
    apb.pwdata  = 32'h1234_5678;
    apb.pstrb   = 4'hF;
    @(posedge pclk); #1;
    apb.penable = 1'b1;
    preset      = 1'b1;
    @(posedge pclk); #1;
    preset      = 1'b0;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    idle(3);
    expect_no_pulse(p0, "reset_mid_pready");
    xfer(1'b0, 8'h14, 32'h0, 4'h0, 32'h0000_0000, 1'b0, 1'b0, "rd_14_after_reset");
    xfer(1'b0, 8'h08, 32'h0, 4'h0, 32'h0000_0000, 1'b0, 1'b0, "rd_08_cleared");
    idle(3);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb4_completer_regfile.md
APB4_COMPLETER_REGFILE -- requirements
Module: peripheral_apb4_completer_regfile

Interface
REQ-001 SHALL provide parameter PADDR_SIZE, default 8, APB address width in bits.
REQ-002 SHALL provide parameter PDATA_SIZE, default 32, APB data width; multiple of 8.
REQ-003 SHALL provide parameter NUM_REGS, default 16, number of PDATA_SIZE-bit registers.
REQ-004 SHALL provide parameter WAIT_CYCLES, default 1, wait states inserted per access (0..15).
REQ-005 pclk  input  1  single clock; all state updates on rising edge.
REQ-006 preset  input  1  reset, synchronous, active-high.
REQ-007 psel  input  1  completer select from requester.
REQ-008 penable  input  1  access-phase indicator.
REQ-009 pwrite  input  1  1 = write, 0 = read.
REQ-010 paddr  input  PADDR_SIZE  byte address; word index = paddr >> log2(PDATA_SIZE/8).
REQ-011 pstrb  input  PDATA_SIZE/8  write byte-lane enables.
REQ-012 pwdata  input  PDATA_SIZE  write data.
REQ-013 prdata  output  PDATA_SIZE  read data, registered, valid only while pready=1 on a read.
REQ-014 pready  output  1  transfer completion, registered.
REQ-015 pslverr  output  1  transfer error, registered, valid only while pready=1.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, DONE.
REQ-017 IDLE: psel=1 & penable=0 (setup cycle T0) SHALL load wait counter with WAIT_CYCLES and go to WAIT; if WAIT_CYCLES=0, go directly to DONE.
REQ-018 WAIT: counter SHALL decrement each cycle; transition to DONE at the edge where counter reaches 1.
REQ-019 pready SHALL be 1 exactly in cycle T0+1+WAIT_CYCLES (DONE state) and 0 in all other cycles.
REQ-020 DONE SHALL return to IDLE unconditionally after one cycle; a setup cycle immediately following SHALL be accepted from IDLE (back-to-back transfers, one idle-free gap).
REQ-021 Address, pwrite, pstrb, pwdata SHALL be captured at the setup-cycle edge; later changes during WAIT SHALL be ignored.
REQ-022 Write commit SHALL occur at the edge ending the DONE cycle, only if psel=1 & penable=1 and no error; byte lane i updated iff pstrb[i]=1.
REQ-023 pstrb all-zero write SHALL complete with pslverr=0 and no register change.
REQ-024 Read data SHALL be loaded into prdata at the edge entering DONE; reads ignore pstrb.
REQ-025 Word index >= NUM_REGS SHALL give pslverr=1 in DONE, no write, prdata=0.
REQ-026 Unaligned paddr (low log2(PDATA_SIZE/8) bits nonzero) SHALL give pslverr=1, no write, prdata=0.
REQ-027 Abort: psel=0 or penable=0 observed in WAIT or DONE SHALL return FSM to IDLE next edge, pready=0, no write.
REQ-028 penable=1 in IDLE without preceding setup SHALL be ignored (no transfer).
REQ-029 Outside DONE, prdata and pslverr SHALL be driven 0.

Reset
REQ-030 preset=1 at a rising edge SHALL set FSM=IDLE, counter=0, pready=0, pslverr=0, prdata=0, all registers=0.
REQ-031 Reset asserted mid-transfer SHALL abandon it with no write; first setup after preset deasserts SHALL be accepted.
REQ-032 preset SHALL take priority over any concurrent APB activity.

Verification
REQ-033 Reset then read idx 3 (paddr=0x0C), WAIT_CYCLES=1 -> pready high in T0+2, prdata=0x00000000, pslverr=0.
REQ-034 Write paddr=0x08, pwdata=0xDEADBEEF, pstrb=4'b0101, then read 0x08 -> prdata=0x00AD00EF.
REQ-035 Read paddr=0x40 (idx 16, NUM_REGS=16) -> pslverr=1, prdata=0; write 0x41 -> pslverr=1, no register changed.
REQ-036 Back-to-back writes to 0x00 and 0x04 with only setup/access cycles -> both complete, each pready pulse one cycle wide.
REQ-037 Drop psel during WAIT of a write to 0x10 -> pready stays 0, readback of 0x10 unchanged.
REQ-038 Assert preset during WAIT of write 0x14=0x12345678 -> pready=0, readback of 0x14 = 0.
